// File: rtl/mips_isa_pkg.sv
// rtl/mips_isa_pkg.sv - MIPS mnemonic codes, opcode/funct values, field positions and word packers
package mips_isa_pkg;

    // Mnemonic codes carried on the encoder input stream; 26..31 are illegal.
    typedef enum logic [4:0] {
        MN_ADD, MN_ADDU, MN_SUB, MN_SUBU, MN_AND, MN_OR, MN_XOR, MN_NOR,
        MN_SLT, MN_SLTU, MN_SLL, MN_SRL, MN_SRA, MN_JR, MN_JALR,
        MN_LW, MN_SW, MN_ADDI, MN_ADDIU, MN_ANDI, MN_SLTI, MN_SLTIU,
        MN_BEQ, MN_LUI, MN_J, MN_JAL
    } mnem_e;

    // Primary opcodes, shared with the Control decoder.
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // R-type funct codes.
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2a;
    localparam logic [5:0] FN_SLTU = 6'h2b;

    // Field least-significant bit positions in the machine word.
    localparam int OP_LSB    = 26;
    localparam int RS_LSB    = 21;
    localparam int RT_LSB    = 16;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_LSB = 6;
    localparam int FUNCT_LSB = 0;

    function automatic logic [31:0] packR(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] shamt,
                                          input logic [5:0] funct);
        logic [31:0] w;
        w = '0;
        w[OP_LSB +: 6]    = OP_RTYPE;
        w[RS_LSB +: 5]    = rs;
        w[RT_LSB +: 5]    = rt;
        w[RD_LSB +: 5]    = rd;
        w[SHAMT_LSB +: 5] = shamt;
        w[FUNCT_LSB +: 6] = funct;
        return w;
    endfunction

    function automatic logic [31:0] packI(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        logic [31:0] w;
        w = '0;
        w[OP_LSB +: 6] = op;
        w[RS_LSB +: 5] = rs;
        w[RT_LSB +: 5] = rt;
        w[15:0]        = imm;
        return w;
    endfunction

    function automatic logic [31:0] packJ(input logic [5:0] op, input logic [25:0] target);
        logic [31:0] w;
        w = '0;
        w[OP_LSB +: 6] = op;
        w[25:0]        = target;
        return w;
    endfunction

endpackage

// File: rtl/inst_encoder_loader_if.sv
// rtl/inst_encoder_loader_if.sv - field-bundle stream and instruction-memory write bus
// master: program-load host (drives in_* bundle, sees in_ready and the imem write)
// slave : encoder/loader (accepts in_* bundle, drives in_ready and imem_we/addr/wdata)
interface inst_encoder_loader_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_mnem;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [4:0]        in_shamt;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              in_last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output in_valid, in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, in_last,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, in_last,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/inst_pack.sv
// rtl/inst_pack.sv - combinational mnemonic+fields to 32-bit MIPS word packer
// Ports: mnem/rs/rt/rd/shamt/imm/target in; word out, illegal out (mnemonic 26..31)
module inst_pack
    import mips_isa_pkg::*;
(
    input  logic [4:0]  mnem,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal
);

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (mnem)
            MN_ADD:   word = packR(rs, rt, rd, 5'd0, FN_ADD);
            MN_ADDU:  word = packR(rs, rt, rd, 5'd0, FN_ADDU);
            MN_SUB:   word = packR(rs, rt, rd, 5'd0, FN_SUB);
            MN_SUBU:  word = packR(rs, rt, rd, 5'd0, FN_SUBU);
            MN_AND:   word = packR(rs, rt, rd, 5'd0, FN_AND);
            MN_OR:    word = packR(rs, rt, rd, 5'd0, FN_OR);
            MN_XOR:   word = packR(rs, rt, rd, 5'd0, FN_XOR);
            MN_NOR:   word = packR(rs, rt, rd, 5'd0, FN_NOR);
            MN_SLT:   word = packR(rs, rt, rd, 5'd0, FN_SLT);
            MN_SLTU:  word = packR(rs, rt, rd, 5'd0, FN_SLTU);
            // Shifts take their operand from rt, so rs is forced to zero.
            MN_SLL:   word = packR(5'd0, rt, rd, shamt, FN_SLL);
            MN_SRL:   word = packR(5'd0, rt, rd, shamt, FN_SRL);
            MN_SRA:   word = packR(5'd0, rt, rd, shamt, FN_SRA);
            MN_JR:    word = packR(rs, 5'd0, 5'd0, 5'd0, FN_JR);
            MN_JALR:  word = packR(rs, 5'd0, rd, 5'd0, FN_JALR);
            MN_LW:    word = packI(OP_LW, rs, rt, imm);
            MN_SW:    word = packI(OP_SW, rs, rt, imm);
            MN_ADDI:  word = packI(OP_ADDI, rs, rt, imm);
            MN_ADDIU: word = packI(OP_ADDIU, rs, rt, imm);
            MN_ANDI:  word = packI(OP_ANDI, rs, rt, imm);
            MN_SLTI:  word = packI(OP_SLTI, rs, rt, imm);
            MN_SLTIU: word = packI(OP_SLTIU, rs, rt, imm);
            MN_BEQ:   word = packI(OP_BEQ, rs, rt, imm);
            MN_LUI:   word = packI(OP_LUI, 5'd0, rt, imm);
            MN_J:     word = packJ(OP_J, target);
            MN_JAL:   word = packJ(OP_JAL, target);
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/inst_encoder_loader.sv
// rtl/inst_encoder_loader.sv - encodes field bundles and writes them to consecutive imem words
// Ports: clk, reset (async active-low), start (session pulse), bus (slave: bundle stream in,
//        imem write out), count (words written this session), done/err (sticky session status)
module inst_encoder_loader
    import mips_isa_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    inst_encoder_loader_if.slave bus,
    output logic [ADDR_W:0]     count,
    output logic                done,
    output logic                err
);

    localparam logic [ADDR_W:0] DEPTH_W = DEPTH[ADDR_W:0];

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE, ST_ERR} state_e;

    state_e            state;
    state_e            nextState;
    logic              inReady;
    logic              accept;
    logic              writeEn;
    logic              clearSession;
    logic              setDone;
    logic              setErr;
    logic [31:0]       packWord;
    logic              packIllegal;
    logic              imemWe;
    logic [ADDR_W-1:0] imemAddr;
    logic [31:0]       imemWdata;

    inst_pack u_pack (
        .mnem    (bus.in_mnem),
        .rs      (bus.in_rs),
        .rt      (bus.in_rt),
        .rd      (bus.in_rd),
        .shamt   (bus.in_shamt),
        .imm     (bus.in_imm),
        .target  (bus.in_target),
        .word    (packWord),
        .illegal (packIllegal)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState    = state;
        clearSession = 1'b0;
        setDone      = 1'b0;
        setErr       = 1'b0;
        inReady      = (state == ST_RUN) && (count < DEPTH_W);
        accept       = bus.in_valid && inReady;
        writeEn      = accept && !packIllegal;
        case (state)
            ST_RUN: begin
                if (accept) begin
                    if (packIllegal) begin
                        nextState = ST_ERR;
                        setErr    = 1'b1;
                    end else if (bus.in_last) begin
                        nextState = ST_DONE;
                        setDone   = 1'b1;
                    end
                end else if (bus.in_valid) begin
                    // Only reachable with count == DEPTH: the host tried to push past the end.
                    nextState = ST_ERR;
                    setErr    = 1'b1;
                end
            end
            default: begin
                if (start) begin
                    nextState    = ST_RUN;
                    clearSession = 1'b1;
                end
            end
        endcase
    end

    // The write is issued from registers so address/data are stable for the whole write cycle;
    // count moves on the transfer edge so in_ready already reflects the new fill level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            imemWe    <= 1'b0;
            imemAddr  <= '0;
            imemWdata <= '0;
            count     <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            imemWe <= writeEn;
            if (writeEn) begin
                imemAddr  <= count[ADDR_W-1:0];
                imemWdata <= packWord;
                count     <= count + 1'b1;
            end
            if (clearSession) begin
                count <= '0;
                done  <= 1'b0;
                err   <= 1'b0;
            end else begin
                if (setDone) done <= 1'b1;
                if (setErr)  err  <= 1'b1;
            end
        end
    end

    assign bus.in_ready   = inReady;
    assign bus.imem_we    = imemWe;
    assign bus.imem_addr  = imemAddr;
    assign bus.imem_wdata = imemWdata;

endmodule

// File: tb/tb_inst_encoder_loader.sv
// tb/tb_inst_encoder_loader.sv - self-checking bench for inst_encoder_loader
module tb_inst_encoder_loader;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              reset;
    logic              start;
    logic [ADDR_W:0]   count;
    logic              done;
    logic              err;

    inst_encoder_loader_if #(.ADDR_W(ADDR_W)) bus ();

    inst_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bus   (bus),
        .count (count),
        .done  (done),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference tables straight from the ISA listing.
    int functTab [15] = '{32, 33, 34, 35, 36, 37, 38, 39, 42, 43, 0, 2, 3, 8, 9};
    int iopTab   [9]  = '{35, 43, 8, 9, 12, 10, 11, 4, 15};

    // Session model: what the host should see.
    bit          mRun, mDone, mErr, mWe;
    int          mCount, mAddr;
    logic [31:0] mWdata;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] refEncode(input int m, input int rs, input int rt, input int rd,
                                              input int sh, input int imm, input int tgt,
                                              output bit legal);
        longint w;
        legal = 1'b1;
        w = 0;
        if (m <= 9)                  w = rs * 64'h200000 + rt * 64'h10000 + rd * 64'h800 + functTab[m];
        else if (m <= 12)            w = rt * 64'h10000 + rd * 64'h800 + sh * 64'h40 + functTab[m];
        else if (m == 13)            w = rs * 64'h200000 + functTab[m];
        else if (m == 14)            w = rs * 64'h200000 + rd * 64'h800 + functTab[m];
        else if (m <= 22)            w = iopTab[m-15] * 64'h4000000 + rs * 64'h200000 + rt * 64'h10000 + imm;
        else if (m == 23)            w = iopTab[8] * 64'h4000000 + rt * 64'h10000 + imm;
        else if (m == 24 || m == 25) w = (m - 22) * 64'h4000000 + tgt;
        else                         legal = 1'b0;
        return w[31:0];
    endfunction

    task automatic setB(input int m, input int rs, input int rt, input int rd, input int sh,
                        input int imm, input int tgt, input bit last, input bit valid);
        bus.in_mnem   = 5'(m);
        bus.in_rs     = 5'(rs);
        bus.in_rt     = 5'(rt);
        bus.in_rd     = 5'(rd);
        bus.in_shamt  = 5'(sh);
        bus.in_imm    = 16'(imm);
        bus.in_target = 26'(tgt);
        bus.in_last   = last;
        bus.in_valid  = valid;
    endtask

    task automatic modelClear();
        mRun = 0; mDone = 0; mErr = 0; mWe = 0; mCount = 0; mAddr = 0; mWdata = '0;
    endtask

    task automatic checkResetVals(input string tag);
        checkEq({tag, "_ready"}, 32'(bus.in_ready), 0);
        checkEq({tag, "_we"},    32'(bus.imem_we), 0);
        checkEq({tag, "_addr"},  32'(bus.imem_addr), 0);
        checkEq({tag, "_wdata"}, bus.imem_wdata, 0);
        checkEq({tag, "_count"}, 32'(count), 0);
        checkEq({tag, "_done"},  32'(done), 0);
        checkEq({tag, "_err"},   32'(err), 0);
    endtask

    // Apply the session rules to the inputs held over the coming edge, then compare after it.
    task automatic step();
        bit          rdy, legal;
        logic [31:0] w;
        rdy = mRun && (mCount < DEPTH);
        mWe = 0;
        if (!mRun) begin
            if (start) begin mRun = 1; mCount = 0; mDone = 0; mErr = 0; end
        end else if (bus.in_valid && rdy) begin
            w = refEncode(int'(bus.in_mnem), int'(bus.in_rs), int'(bus.in_rt), int'(bus.in_rd),
                          int'(bus.in_shamt), int'(bus.in_imm), int'(bus.in_target), legal);
            if (!legal) begin
                mRun = 0; mErr = 1;
            end else begin
                mWe = 1; mAddr = mCount; mWdata = w; mCount++;
                if (bus.in_last) begin mRun = 0; mDone = 1; end
            end
        end else if (bus.in_valid) begin
            mRun = 0; mErr = 1;
        end
        @(posedge clk);
        #1;
        checkEq("ready", 32'(bus.in_ready), 32'(mRun && (mCount < DEPTH)));
        checkEq("we",    32'(bus.imem_we), 32'(mWe));
        if (mWe) begin
            checkEq("addr",  32'(bus.imem_addr), 32'(mAddr));
            checkEq("wdata", bus.imem_wdata, mWdata);
        end
        checkEq("count", 32'(count), 32'(mCount));
        checkEq("done",  32'(done), 32'(mDone));
        checkEq("err",   32'(err), 32'(mErr));
    endtask

    task automatic doReset();
        reset = 0; start = 0;
        setB(0, 0, 0, 0, 0, 0, 0, 0, 0);
        modelClear();
        @(posedge clk);
        #1;
        checkResetVals("rst");
        @(negedge clk);
        reset = 1;
    endtask

    initial begin
        doReset();

        // Session 1: add, lw, sll, ignored start, beq last.
        start = 1; step(); start = 0;
        setB(0, 1, 2, 3, 0, 0, 0, 0, 1); step();
        checkEq("add_word", bus.imem_wdata, 32'h00221820);
        checkEq("add_addr", 32'(bus.imem_addr), 0);
        setB(15, 29, 8, 0, 0, 4, 0, 0, 1); step();
        checkEq("lw_word", bus.imem_wdata, 32'h8FA80004);
        setB(10, 7, 1, 2, 4, 0, 0, 0, 1); step();
        checkEq("sll_word", bus.imem_wdata, 32'h00011100);
        setB(0, 0, 0, 0, 0, 0, 0, 0, 0); start = 1; step(); start = 0;
        checkEq("start_ignored_count", 32'(count), 3);
        setB(22, 3, 4, 0, 0, 16'hFFFE, 0, 1, 1); step();
        checkEq("beq_word", bus.imem_wdata, 32'h1064FFFE);
        checkEq("full_ready", 32'(bus.in_ready), 0);
        setB(0, 0, 0, 0, 0, 0, 0, 0, 0); step();

        // Session 2: j then jal last; start lands on the final write cycle.
        start = 1; step(); start = 0;
        checkEq("s2_count0", 32'(count), 0);
        setB(24, 0, 0, 0, 0, 0, 26'h0100000, 0, 1); step();
        checkEq("j_word", bus.imem_wdata, 32'h08100000);
        setB(25, 0, 0, 0, 0, 0, 26'h0100000, 1, 1); step();
        checkEq("jal_word", bus.imem_wdata, 32'h0C100000);
        checkEq("jal_count", 32'(count), 2);
        checkEq("jal_done", 32'(done), 1);
        checkEq("jal_ready", 32'(bus.in_ready), 0);
        setB(0, 0, 0, 0, 0, 0, 0, 0, 0); start = 1; step(); start = 0;
        checkEq("restart_count", 32'(count), 0);
        checkEq("restart_done", 32'(done), 0);

        // Illegal mnemonic, then restart at address 0.
        setB(27, 1, 2, 3, 0, 0, 0, 0, 1); step();
        checkEq("illegal_we", 32'(bus.imem_we), 0);
        checkEq("illegal_err", 32'(err), 1);
        setB(0, 0, 0, 0, 0, 0, 0, 0, 0); start = 1; step(); start = 0;
        checkEq("err_cleared", 32'(err), 0);
        setB(1, 5, 6, 7, 0, 0, 0, 1, 1); step();
        checkEq("after_err_addr", 32'(bus.imem_addr), 0);

        // Overflow: five bundles with valid held high into a four-word memory.
        setB(0, 0, 0, 0, 0, 0, 0, 0, 0); start = 1; step(); start = 0;
        for (int k = 0; k < 5; k++) begin
            setB($urandom_range(0, 25), $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 31), $urandom_range(0, 65535), $urandom_range(0, 32'h3FFFFFF), 0, 1);
            step();
            if (k == 3) begin
                checkEq("ovf_last_addr", 32'(bus.imem_addr), 3);
                checkEq("ovf_ready", 32'(bus.in_ready), 0);
            end
        end
        checkEq("ovf_err", 32'(err), 1);
        checkEq("ovf_no_write", 32'(bus.imem_we), 0);
        setB(0, 0, 0, 0, 0, 0, 0, 0, 0); step();

        // Reset the cycle right after a transfer: the pending write is dropped at once.
        start = 1; step(); start = 0;
        setB(2, 9, 9, 9, 0, 0, 0, 0, 1); step();
        setB(0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 0;
        #1;
        checkResetVals("midrst");
        modelClear();
        @(negedge clk);
        reset = 1;
        step();

        // Random sessions.
        for (int s = 0; s < 12; s++) begin
            setB(0, 0, 0, 0, 0, 0, 0, 0, 0); start = 1; step(); start = 0;
            for (int c = 0; c < 12; c++) begin
                setB(($urandom_range(0, 15) == 0) ? $urandom_range(26, 31) : $urandom_range(0, 25),
                     $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom_range(0, 31), $urandom_range(0, 65535), $urandom_range(0, 32'h3FFFFFF),
                     $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0);
                start = ($urandom_range(0, 15) == 0);
                step();
            end
            start = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
